fpnew_round_pipe: RTL and testbench
===================================

FPNEW_ROUND_PIPE -- requirements
Module: fpnew_round_pipe

Interface
REQ-001 SHALL have parameter AbsWidth, default 8: magnitude width in bits (>=2).
REQ-002 SHALL have parameter NumPipeRegs, default 1: output register stages (0..4).
REQ-003 SHALL have parameter TagWidth, default 4: width of the opaque pass-through tag (>=1).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports abs_value_i  input  AbsWidth, sign_i  input  1, round_sticky_bits_i  input  2 ({round, sticky}), rnd_mode_i  input  3, effective_subtraction_i  input  1, tag_i  input  TagWidth.
REQ-007 SHALL have ports in_valid_i  input  1, in_ready_o  output  1, flush_i  input  1 (kill all in-flight operations).
REQ-008 SHALL have ports abs_rounded_o  output  AbsWidth, sign_o  output  1, exact_zero_o  output  1, inexact_o  output  1, carry_o  output  1 (increment overflowed AbsWidth), tag_o  output  TagWidth.
REQ-009 SHALL have ports out_valid_o  output  1, out_ready_i  input  1, busy_o  output  1 (any stage valid).

Function
REQ-010 SHALL decide round_up as: RNE 000: rs=0x->0, 10->abs_value_i[0], 11->1; RTZ 001: 0; RDN 010: sign_i when rs!=0; RUP 011: ~sign_i when rs!=0; RMM 100: rs[1]; ROD 101: ~abs_value_i[0] when rs!=0; encodings 110/111: 0.
REQ-011 SHALL compute {carry, abs_rounded} = abs_value_i + round_up at AbsWidth+1 bits; abs_rounded wraps to zero on carry.
REQ-012 SHALL assert exact_zero when abs_value_i==0 and rs==00; inexact when rs!=00.
REQ-013 SHALL output sign = (rnd_mode_i==RDN) when exact_zero and effective_subtraction_i, otherwise sign_i.
REQ-014 SHALL perform all rounding combinationally ahead of the first register; registers carry results only.
REQ-015 SHALL, with NumPipeRegs=0, be purely combinational: out_valid_o=in_valid_i, in_ready_o=out_ready_i, flush_i ignored.
REQ-016 SHALL, with NumPipeRegs=N>0, have latency N cycles from accepted input to out_valid_o with no stalls; throughput one op per cycle.
REQ-017 SHALL let stage k load when it is empty or stage k+1 (or output for last stage) accepts in the same cycle; in_ready_o = stage-0 ready.
REQ-018 SHALL transfer an input only when in_valid_i and in_ready_o are high; output consumed only when out_valid_o and out_ready_i are high.
REQ-019 SHALL hold a stalled stage's data and valid stable while out_ready_i is low; order is strictly preserved.
REQ-020 SHALL, on flush_i high, clear every stage valid at the next edge and discard any input presented that cycle; data registers may keep values.
REQ-021 SHALL give flush_i priority over simultaneous accept and output handshakes; an output handshaked in the flush cycle counts as delivered.
REQ-022 SHALL gate data register enables with the stage load condition (no toggling when idle).

Reset
REQ-023 SHALL, with rst_ni low at a clock edge, clear all stage valid bits and all data/tag registers to 0.
REQ-024 SHALL present out_valid_o=0, busy_o=0, in_ready_o=1, all data outputs 0 during and after reset until first accept.
REQ-025 SHALL, on reset mid-operation, drop in-flight ops without emitting them; reset overrides flush.

Structure
REQ-026 SHALL take rounding-mode encodings, including new ROD=3'b101, from fpnew_pkg (roundmode_e); no local copies.
REQ-027 SHALL instantiate fpnew_rounding_core (the combinational REQ-010..013 logic) once, feeding a generated array of NumPipeRegs register stages.

Verification (AbsWidth=8, NumPipeRegs=2, out_ready_i=1 unless stated)
REQ-028 SHALL cover RNE tie: abs=0x05, rs=10, sign=0 -> two cycles later abs_rounded=0x06, inexact=1, carry=0.
REQ-029 SHALL cover carry wrap: abs=0xFF, rs=11, RNE -> abs_rounded=0x00, carry=1, exact_zero=0.
REQ-030 SHALL cover ROD and exact-zero sign: abs=0x04, rs=01, ROD -> 0x05; abs=0x00, rs=00, RDN, eff_sub=1, sign=0 -> sign_o=1, exact_zero=1.
REQ-031 SHALL cover backpressure: out_ready_i=0, three back-to-back inputs tags 1,2,3 -> tags 1,2 held, in_ready_o=0 with tag 3 waiting; release -> tags 1,2,3 out in order, one per cycle.
REQ-032 SHALL cover flush and reset: two ops in flight, flush_i pulse -> out_valid_o=0 next cycle, busy_o=0; repeat with rst_ni low -> all outputs 0.

Source files
------------

// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_pkg
//  Brief    : Shared rounding-mode encodings for the FPnew rounding blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package fpnew_pkg;

   // IEEE-754 rounding modes plus round-to-odd used by the rounding logic.
   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      ROD = 3'b101
   } roundmode_e;

   // Per-operation bookkeeping bits stored next to the magnitude and tag.
   localparam int unsigned FlagBits = 4;

endpackage
`default_nettype wire

// File: rtl/fpnew_rounding_core.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_rounding_core
//  Brief    : Combinational rounding of a magnitude using round/sticky bits.
//  Revision : 1.0 - initial release
// ============================================================================
module fpnew_rounding_core
   import fpnew_pkg::*;
#(
   parameter int unsigned AbsWidth = 8
) (
   input  logic [AbsWidth-1:0] abs_value,
   input  logic                sign,
   input  logic [1:0]          round_sticky,
   input  roundmode_e          rnd_mode,
   input  logic                eff_sub,
   output logic [AbsWidth-1:0] abs_rounded,
   output logic                carry,
   output logic                exact_zero,
   output logic                inexact,
   output logic                sign_rounded
);

   logic              round_up;
   logic              any_rs;
   logic [AbsWidth:0] sum;

   assign any_rs = |round_sticky;

   // Decide whether the magnitude must be incremented for the selected mode.
   always_comb begin
      round_up = 1'b0;
      unique case (rnd_mode)
         RNE: begin
            unique case (round_sticky)
               2'b10:   round_up = abs_value[0];
               2'b11:   round_up = 1'b1;
               default: round_up = 1'b0;
            endcase
         end
         RTZ:     round_up = 1'b0;
         RDN:     round_up = any_rs & sign;
         RUP:     round_up = any_rs & ~sign;
         RMM:     round_up = round_sticky[1];
         ROD:     round_up = any_rs & ~abs_value[0];
         default: round_up = 1'b0;
      endcase
   end

   // The extra top bit captures overflow; the magnitude itself wraps to zero.
   assign sum         = {1'b0, abs_value} + {{AbsWidth{1'b0}}, round_up};
   assign abs_rounded = sum[AbsWidth-1:0];
   assign carry       = sum[AbsWidth];

   assign exact_zero  = (abs_value == '0) && !any_rs;
   assign inexact     = any_rs;

   // An exact zero from an effective subtraction is -0 only when rounding down.
   assign sign_rounded = (exact_zero && eff_sub) ? (rnd_mode == RDN) : sign;

endmodule
`default_nettype wire

// File: rtl/fpnew_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_round_pipe
//  Brief    : Rounding core followed by an elastic valid/ready register chain.
//  Revision : 1.0 - initial release
// ============================================================================
module fpnew_round_pipe
   import fpnew_pkg::*;
#(
   parameter int unsigned AbsWidth    = 8,
   parameter int unsigned NumPipeRegs = 1,
   parameter int unsigned TagWidth    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [AbsWidth-1:0] abs_value_i,
   input  logic                sign_i,
   input  logic [1:0]          round_sticky_bits_i,
   input  logic [2:0]          rnd_mode_i,
   input  logic                effective_subtraction_i,
   input  logic [TagWidth-1:0] tag_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                flush_i,
   output logic [AbsWidth-1:0] abs_rounded_o,
   output logic                sign_o,
   output logic                exact_zero_o,
   output logic                inexact_o,
   output logic                carry_o,
   output logic [TagWidth-1:0] tag_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                busy_o
);

   localparam int unsigned DataWidth = TagWidth + FlagBits + AbsWidth;

   logic [AbsWidth-1:0]  rounded_abs;
   logic                 rounded_carry;
   logic                 rounded_zero;
   logic                 rounded_inexact;
   logic                 rounded_sign;
   logic [DataWidth-1:0] data_in;
   logic [DataWidth-1:0] data_out;

   fpnew_rounding_core #(
      .AbsWidth (AbsWidth)
   ) u_core (
      .abs_value    (abs_value_i),
      .sign         (sign_i),
      .round_sticky (round_sticky_bits_i),
      .rnd_mode     (roundmode_e'(rnd_mode_i)),
      .eff_sub      (effective_subtraction_i),
      .abs_rounded  (rounded_abs),
      .carry        (rounded_carry),
      .exact_zero   (rounded_zero),
      .inexact      (rounded_inexact),
      .sign_rounded (rounded_sign)
   );

   assign data_in = {tag_i, rounded_sign, rounded_zero, rounded_inexact,
                     rounded_carry, rounded_abs};

   generate
      if (NumPipeRegs == 0) begin : g_comb
         logic unused_pipe_ctrl;
         assign unused_pipe_ctrl = ^{clk_i, rst_ni, flush_i};
         assign data_out    = data_in;
         assign out_valid_o = in_valid_i;
         assign in_ready_o  = out_ready_i;
         assign busy_o      = 1'b0;
      end else begin : g_pipe
         logic [NumPipeRegs-1:0] valid_q;
         logic [DataWidth-1:0]   data_q [NumPipeRegs];
         logic [NumPipeRegs:0]   accept;

         // A stage may load when it is empty or its downstream neighbour takes its content.
         always_comb begin
            accept[NumPipeRegs] = out_ready_i;
            for (int k = int'(NumPipeRegs) - 1; k >= 0; k--) begin
               accept[k] = ~valid_q[k] | accept[k+1];
            end
         end

         // Advance the register chain; reset beats flush, flush beats any handshake.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               for (int k = 0; k < int'(NumPipeRegs); k++) begin
                  valid_q[k] <= 1'b0;
                  data_q[k]  <= '0;
               end
            end else begin
               if (flush_i) begin
                  valid_q[0] <= 1'b0;
               end else if (accept[0]) begin
                  valid_q[0] <= in_valid_i;
               end
               if (accept[0] && in_valid_i) begin
                  data_q[0] <= data_in;
               end
               for (int k = 1; k < int'(NumPipeRegs); k++) begin
                  if (flush_i) begin
                     valid_q[k] <= 1'b0;
                  end else if (accept[k]) begin
                     valid_q[k] <= valid_q[k-1];
                  end
                  if (accept[k] && valid_q[k-1]) begin
                     data_q[k] <= data_q[k-1];
                  end
               end
            end
         end

         assign data_out    = data_q[NumPipeRegs-1];
         assign out_valid_o = valid_q[NumPipeRegs-1];
         assign in_ready_o  = accept[0];
         assign busy_o      = |valid_q;
      end
   endgenerate

   assign tag_o         = data_out[DataWidth-1 -: TagWidth];
   assign sign_o        = data_out[AbsWidth+3];
   assign exact_zero_o  = data_out[AbsWidth+2];
   assign inexact_o     = data_out[AbsWidth+1];
   assign carry_o       = data_out[AbsWidth];
   assign abs_rounded_o = data_out[AbsWidth-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fpnew_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpnew_round_pipe
//  Brief    : Directed self-checking bench for fpnew_round_pipe (2 stages).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_round_pipe;
   import fpnew_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic [7:0] abs_value_i = '0;
   logic       sign_i = 1'b0;
   logic [1:0] round_sticky_bits_i = '0;
   logic [2:0] rnd_mode_i = '0;
   logic       effective_subtraction_i = 1'b0;
   logic [3:0] tag_i = '0;
   logic       in_valid_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       out_ready_i = 1'b1;
   logic       in_ready_o;
   logic [7:0] abs_rounded_o;
   logic       sign_o, exact_zero_o, inexact_o, carry_o, out_valid_o, busy_o;
   logic [3:0] tag_o;

   int vectors = 0;
   int miscompares = 0;

   // {valid, tag, sign, exact_zero, inexact, carry, abs}
   wire [16:0] obs = {out_valid_o, tag_o, sign_o, exact_zero_o, inexact_o,
                      carry_o, abs_rounded_o};

   localparam logic [7:0] M_ABS  [9] = '{8'h10, 8'h10, 8'h10, 8'h2A, 8'h06, 8'h06, 8'h06, 8'h07, 8'h20};
   localparam logic [1:0] M_RS   [9] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
   localparam logic [2:0] M_MODE [9] = '{RDN, RUP, RUP, RTZ, RMM, RNE, 3'b110, RNE, RUP};
   localparam logic       M_SIGN [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [7:0] M_EXP  [9] = '{8'h11, 8'h10, 8'h11, 8'h2A, 8'h07, 8'h06, 8'h06, 8'h07, 8'h20};

   fpnew_round_pipe #(
      .AbsWidth    (8),
      .NumPipeRegs (2),
      .TagWidth    (4)
   ) dut (
      .clk_i                   (clk_i),
      .rst_ni                  (rst_ni),
      .abs_value_i             (abs_value_i),
      .sign_i                  (sign_i),
      .round_sticky_bits_i     (round_sticky_bits_i),
      .rnd_mode_i              (rnd_mode_i),
      .effective_subtraction_i (effective_subtraction_i),
      .tag_i                   (tag_i),
      .in_valid_i              (in_valid_i),
      .in_ready_o              (in_ready_o),
      .flush_i                 (flush_i),
      .abs_rounded_o           (abs_rounded_o),
      .sign_o                  (sign_o),
      .exact_zero_o            (exact_zero_o),
      .inexact_o               (inexact_o),
      .carry_o                 (carry_o),
      .tag_o                   (tag_o),
      .out_valid_o             (out_valid_o),
      .out_ready_i             (out_ready_i),
      .busy_o                  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [1:0] rs, input logic [2:0] m,
                        input logic s, input logic es, input logic [3:0] t);
      abs_value_i             = a;
      round_sticky_bits_i     = rs;
      rnd_mode_i              = m;
      sign_i                  = s;
      effective_subtraction_i = es;
      tag_i                   = t;
      in_valid_i              = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(8'hFF, 2'b11, RNE, 1'b1, 1'b0, 4'hF);
      tick();
      tick();
      vectors++;
      if ({obs, busy_o, in_ready_o} !== {17'h0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset: got %h/%b/%b expected 00000/0/1", obs, busy_o, in_ready_o);
      end
      in_valid_i = 1'b0;
      rst_ni = 1'b1;
      tick();
      vectors++;
      if ({obs, busy_o} !== {17'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL post_reset: got %h/%b expected 00000/0", obs, busy_o);
      end
   endtask

   task automatic test_rne_tie();
      drive(8'h05, 2'b10, RNE, 1'b0, 1'b0, 4'h1);
      tick();
      in_valid_i = 1'b0;
      vectors++;
      if (out_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rne_latency1: got valid %b expected 0", out_valid_o);
      end
      tick();
      vectors++;
      if (obs !== {1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h06}) begin
         miscompares++;
         $display("FAIL rne_tie: got %h expected %h", obs, {1'b1, 4'h1, 4'b0010, 8'h06});
      end
      tick();
      vectors++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL rne_drain: got valid/busy %b%b expected 00", out_valid_o, busy_o);
      end
   endtask

   task automatic test_carry_wrap();
      drive(8'hFF, 2'b11, RNE, 1'b0, 1'b0, 4'h2);
      tick();
      in_valid_i = 1'b0;
      tick();
      vectors++;
      if (obs !== {1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
         miscompares++;
         $display("FAIL carry_wrap: got %h expected %h", obs, {1'b1, 4'h2, 4'b0011, 8'h00});
      end
   endtask

   task automatic test_rod_zero_sign();
      drive(8'h04, 2'b01, ROD, 1'b0, 1'b0, 4'h3);
      tick();
      drive(8'h00, 2'b00, RDN, 1'b0, 1'b1, 4'h4);
      tick();
      drive(8'h00, 2'b00, RNE, 1'b1, 1'b1, 4'h5);
      vectors++;
      if (obs !== {1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05}) begin
         miscompares++;
         $display("FAIL rod: got %h expected %h", obs, {1'b1, 4'h3, 4'b0010, 8'h05});
      end
      tick();
      in_valid_i = 1'b0;
      vectors++;
      if (obs !== {1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL zero_sign_rdn: got %h expected %h", obs, {1'b1, 4'h4, 4'b1100, 8'h00});
      end
      tick();
      vectors++;
      if (obs !== {1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL zero_sign_rne: got %h expected %h", obs, {1'b1, 4'h5, 4'b0100, 8'h00});
      end
      tick();
   endtask

   task automatic test_modes_back_to_back();
      logic [16:0] exp;
      drive(M_ABS[0], M_RS[0], M_MODE[0], M_SIGN[0], 1'b0, 4'h0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k >= 2) begin
            exp = {1'b1, 4'(k-2), M_SIGN[k-2], 1'b0, |M_RS[k-2], 1'b0, M_EXP[k-2]};
            vectors++;
            if (obs !== exp) begin
               miscompares++;
               $display("FAIL mode_vec%0d: got %h expected %h", k-2, obs, exp);
            end
         end
         if (k < 9) drive(M_ABS[k], M_RS[k], M_MODE[k], M_SIGN[k], 1'b0, 4'(k));
         else in_valid_i = 1'b0;
      end
      tick();
   endtask

   task automatic test_back_to_back_backpressure();
      out_ready_i = 1'b0;
      drive(8'h30, 2'b00, RNE, 1'b0, 1'b0, 4'h1);
      tick();
      drive(8'h31, 2'b00, RNE, 1'b0, 1'b0, 4'h2);
      tick();
      drive(8'h32, 2'b00, RNE, 1'b0, 1'b0, 4'h3);
      tick();
      vectors++;
      if ({out_valid_o, tag_o, abs_rounded_o, in_ready_o} !== {1'b1, 4'h1, 8'h30, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_hold1: got v/tag/abs/rdy %b/%h/%h/%b expected 1/1/30/0",
                  out_valid_o, tag_o, abs_rounded_o, in_ready_o);
      end
      tick();
      vectors++;
      if ({out_valid_o, tag_o, abs_rounded_o, in_ready_o} !== {1'b1, 4'h1, 8'h30, 1'b0}) begin
         miscompares++;
         $display("FAIL bp_hold2: got v/tag/abs/rdy %b/%h/%h/%b expected 1/1/30/0",
                  out_valid_o, tag_o, abs_rounded_o, in_ready_o);
      end
      out_ready_i = 1'b1;
      #1;
      vectors++;
      if (in_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release_ready: got %b expected 1", in_ready_o);
      end
      tick();
      in_valid_i = 1'b0;
      vectors++;
      if ({out_valid_o, tag_o} !== {1'b1, 4'h2}) begin
         miscompares++;
         $display("FAIL bp_order2: got v/tag %b/%h expected 1/2", out_valid_o, tag_o);
      end
      tick();
      vectors++;
      if ({out_valid_o, tag_o, abs_rounded_o} !== {1'b1, 4'h3, 8'h32}) begin
         miscompares++;
         $display("FAIL bp_order3: got v/tag/abs %b/%h/%h expected 1/3/32", out_valid_o, tag_o, abs_rounded_o);
      end
      tick();
      vectors++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL bp_drain: got valid/busy %b%b expected 00", out_valid_o, busy_o);
      end
   endtask

   task automatic test_flush();
      drive(8'h40, 2'b00, RNE, 1'b0, 1'b0, 4'h5);
      tick();
      drive(8'h41, 2'b00, RNE, 1'b0, 1'b0, 4'h6);
      tick();
      drive(8'h42, 2'b00, RNE, 1'b0, 1'b0, 4'h7);
      flush_i = 1'b1;
      vectors++;
      if ({out_valid_o, tag_o, busy_o} !== {1'b1, 4'h5, 1'b1}) begin
         miscompares++;
         $display("FAIL flush_pre: got v/tag/busy %b/%h/%b expected 1/5/1", out_valid_o, tag_o, busy_o);
      end
      tick();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      vectors++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_clear: got valid/busy %b%b expected 00", out_valid_o, busy_o);
      end
      tick();
      vectors++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_discard: got valid/busy %b%b expected 00", out_valid_o, busy_o);
      end
   endtask

   task automatic test_reset_mid();
      drive(8'h55, 2'b11, RUP, 1'b0, 1'b0, 4'h8);
      tick();
      drive(8'h66, 2'b01, RNE, 1'b1, 1'b0, 4'h9);
      tick();
      rst_ni = 1'b0;
      flush_i = 1'b1;
      in_valid_i = 1'b0;
      tick();
      vectors++;
      if ({obs, busy_o, in_ready_o} !== {17'h0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_mid: got %h/%b/%b expected 00000/0/1", obs, busy_o, in_ready_o);
      end
      rst_ni = 1'b1;
      flush_i = 1'b0;
      tick();
      tick();
      vectors++;
      if ({obs, busy_o} !== {17'h0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_drop: got %h/%b expected 00000/0", obs, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_rne_tie();
      test_carry_wrap();
      test_rod_zero_sign();
      test_modes_back_to_back();
      test_back_to_back_backpressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
